matrix_result_reader: RTL and testbench
=======================================

Name: matrix_result_reader

Overview:
- Sits directly downstream of RISCVCPU.
- On the rising edge of the CPU `done` flag, snapshots the cycle and instruction counters.
- Reads the M x N2 result matrix out of the byte-wide data memory and assembles big-endian 32-bit signed words.
- Streams the words row-major over a valid/ready interface for on-chip checking or a host link.
- Optionally computes CPI in Q8.8 fixed point.

Parameters:
- M, 2, rows of matrix1 / rows of result.
- N, 4, columns of matrix1 / rows of matrix2.
- N2, 2, columns of matrix2 / columns of result.
- ADDR_W, 8, byte-address width of the data memory read port.

Ports:
- CLOCK_50  in  1  system clock, rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- done  in  1  CPU program-complete flag, level.
- clock_count  in  16  CPU total cycle count.
- instr_cnt  in  16  CPU retired instruction count.
- mem_addr  out  ADDR_W  data memory byte read address.
- mem_rdata  in  8  data memory byte; synchronous, valid 1 cycle after mem_addr.
- out_valid  out  1  result word valid.
- out_ready  in  1  consumer accepts word.
- out_data  out  32  signed result word.
- out_row  out  8  row index of out_data.
- out_col  out  8  column index of out_data.
- out_last  out  1  marks the final word (M*N2-1).
- busy  out  1  high from trigger until FINISHED.
- finished  out  1  high in FINISHED state.
- cycles_snap  out  16  clock_count captured at trigger.
- instrs_snap  out  16  instr_cnt captured at trigger.
- cpi_q8  out  16  CPI, Q8.8 format.

Behaviour:
- Clock and reset: one clock, CLOCK_50. Reset is asynchronous active-low on RESET_N.
- Reset values: all outputs 0, state IDLE, internal done_q = 0.
- Reset mid-operation aborts immediately to IDLE. No partial word is emitted.
- Result base address: RES_BASE = 4*(M*N + N*N2). Element (r,c) is at RES_BASE + 4*(r*N2+c).
- Byte order: the byte at the lower address is the MSB, so word = {B[a], B[a+1], B[a+2], B[a+3]}.
- Trigger: done & ~done_q, where done_q is done registered.
  - On the trigger cycle: snapshot clock_count and instr_cnt, set r = c = 0, go to READ.
  - Triggers outside IDLE are ignored.
- READ:
  - Issue addresses a, a+1, a+2, a+3 on 4 consecutive cycles.
  - Shift mem_rdata into the word register on the following 4 cycles.
  - Go to OUT the cycle after the 4th byte is captured: 5 cycles from READ entry to out_valid.
- OUT:
  - out_valid = 1. out_data, out_row, out_col and out_last are stable while out_valid & ~out_ready.
  - On out_valid & out_ready: advance c, wrapping to 0 and incrementing r at c = N2-1.
  - After the last word, go to CPI (macro defined) or FINISHED; otherwise return to READ.
  - out_valid drops the cycle after acceptance. There are no back-to-back words.
- FINISHED: finished = 1, busy = 0. Return to IDLE when done is low. This re-arms the block for the next program.
- mem_addr holds its last value outside READ.

Optional Feature:
- Macro: MATRIX_RESULT_READER_CPI_EN.
- Defined:
  - A CPI state follows the last word.
  - A restoring divider computes cpi_q8 = (cycles_snap << 8) / instrs_snap, a 24-bit dividend, in 24 cycles.
  - The quotient saturates to 16'hFFFF if it exceeds 16 bits.
  - If instrs_snap == 0, the result is 16'hFFFF with no division performed.
  - busy stays high during CPI. cpi_q8 updates on entry to FINISHED and holds until the next trigger or reset.
- Undefined: no CPI state and no divider logic; cpi_q8 is tied to 0.

Decomposition:
- Package matrix_result_reader_pkg holds:
  - state encoding (IDLE, READ, OUT, CPI, FINISHED);
  - WORD_BYTES = 4;
  - CPI_FRAC_BITS = 8;
  - a RES_BASE calculation function of M, N, N2.
- One sub-module, cpi_divider:
  - start/done handshake;
  - 24-bit dividend, 16-bit divisor;
  - saturating 16-bit quotient.
  - Instantiated only under MATRIX_RESULT_READER_CPI_EN.

Test Plan:
- Basic stream:
  - Stimulus: M=2, N=4, N2=2; matrix1 = 1..8, matrix2 = 1..8; result region (bytes 64..79) preloaded big-endian with 50, 60, 114, 140; pulse done, out_ready = 1.
  - Required response: words 50, 60, 114, 140 with (row,col) (0,0), (0,1), (1,0), (1,1); out_last only on 140; first out_valid exactly 5 cycles after the trigger.
- Sign and byte order:
  - Stimulus: bytes FF FF FF F6 at address 64.
  - Required response: out_data = -10.
- Backpressure:
  - Stimulus: out_ready low for 7 cycles on word 1.
  - Required response: out_valid stays high and out_data = 60 stays stable throughout; no word skipped or duplicated.
- CPI (macro defined):
  - Stimulus: clock_count = 300, instr_cnt = 100 at the trigger → required response: cpi_q8 = 16'h0300.
  - Stimulus: clock_count = 1000, instr_cnt = 3 → required response: cpi_q8 = 16'hFFFF (saturated).
  - Stimulus: instr_cnt = 0 → required response: cpi_q8 = 16'hFFFF.
- Reset and re-arm:
  - Stimulus: assert RESET_N low during READ of word 2.
  - Required response: all outputs 0 immediately; no out_valid afterwards until a new done rising edge.
  - Stimulus: done held high after FINISHED.
  - Required response: no retrigger; after done goes low then high, the full stream repeats.

Source files
------------

// File: rtl/matrix_result_reader_pkg.sv
// Shared types and constants for the matrix result reader.
package matrix_result_reader_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    READ     = 3'd1,
    OUT      = 3'd2,
    CPI      = 3'd3,
    FINISHED = 3'd4
  } state_e;

  localparam int WORD_BYTES    = 4;
  localparam int CPI_FRAC_BITS = 8;

  // The result matrix sits directly after matrix1 (m x n) and matrix2 (n x n2).
  function automatic int res_base(input int m, input int n, input int n2);
    return WORD_BYTES * (m * n + n * n2);
  endfunction

endpackage

// File: rtl/matrix_result_reader_cpi_divider.sv
// Restoring divider producing a saturating 16-bit quotient in 24 cycles.
// A zero divisor short-circuits to 16'hFFFF on the cycle after start.
module cpi_divider (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [23:0] dividend,
  input  logic [15:0] divisor,
  output logic        done,
  output logic [15:0] quotient
);

  logic        busy_q, busy_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] rem_q, rem_d;
  logic [23:0] quo_q, quo_d;
  logic [15:0] div_q, div_d;
  logic        done_q, done_d;
  logic [15:0] result_q, result_d;
  logic [16:0] rem_shift_s;
  logic [16:0] diff_s;

  // Next-state for one restoring step per cycle.
  always_comb begin
    busy_d      = busy_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    div_d       = div_q;
    done_d      = 1'b0;
    result_d    = result_q;
    rem_shift_s = {rem_q, quo_q[23]};
    diff_s      = rem_shift_s - {1'b0, div_q};
    if (start) begin
      if (divisor == 16'd0) begin
        busy_d   = 1'b0;
        done_d   = 1'b1;
        result_d = 16'hFFFF;
      end else begin
        busy_d = 1'b1;
        cnt_d  = 5'd0;
        rem_d  = 16'd0;
        quo_d  = dividend;
        div_d  = divisor;
      end
    end else if (busy_q) begin
      if (!diff_s[16]) begin
        rem_d = diff_s[15:0];
        quo_d = {quo_q[22:0], 1'b1};
      end else begin
        rem_d = rem_shift_s[15:0];
        quo_d = {quo_q[22:0], 1'b0};
      end
      if (cnt_q == 5'd23) begin
        busy_d   = 1'b0;
        done_d   = 1'b1;
        result_d = (quo_d[23:16] != 8'd0) ? 16'hFFFF : quo_d[15:0];
      end else begin
        cnt_d = cnt_q + 5'd1;
      end
    end else begin
      busy_d = 1'b0;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      cnt_q    <= 5'd0;
      rem_q    <= 16'd0;
      quo_q    <= 24'd0;
      div_q    <= 16'd0;
      done_q   <= 1'b0;
      result_q <= 16'd0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      div_q    <= div_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign done     = done_q;
  assign quotient = result_q;

endmodule

// File: rtl/matrix_result_reader.sv
// Streams the CPU result matrix as big-endian signed words after program completion.
// Optional CPI computation is enabled by defining MATRIX_RESULT_READER_CPI_EN.
module matrix_result_reader
  import matrix_result_reader_pkg::*;
#(
  parameter int M      = 2,
  parameter int N      = 4,
  parameter int N2     = 2,
  parameter int ADDR_W = 8
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic              done,
  input  logic [15:0]       clock_count,
  input  logic [15:0]       instr_cnt,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic [7:0]        out_row,
  output logic [7:0]        out_col,
  output logic              out_last,
  output logic              busy,
  output logic              finished,
  output logic [15:0]       cycles_snap,
  output logic [15:0]       instrs_snap,
  output logic [15:0]       cpi_q8
);

  function automatic logic [ADDR_W-1:0] addr_of(input logic [7:0] r, input logic [7:0] c);
    return ADDR_W'(res_base(M, N, N2) + WORD_BYTES * (int'(r) * N2 + int'(c)));
  endfunction

  state_e            state_q, state_d;
  logic              done_q, done_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       word_q, word_d;
  logic [7:0]        row_q, row_d, col_q, col_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              busy_q, busy_d;
  logic              finished_q, finished_d;
  logic [15:0]       cycles_q, cycles_d;
  logic [15:0]       instrs_q, instrs_d;
  logic              trigger_s;
  logic              row_end_s;
  logic [7:0]        nxt_row_s, nxt_col_s;
`ifdef MATRIX_RESULT_READER_CPI_EN
  logic [15:0]       cpi_q, cpi_d;
  logic              div_start_q, div_start_d;
  logic              div_done_s;
  logic [15:0]       div_quo_s;
`endif

  // Controller next-state and datapath updates.
  always_comb begin
    state_d     = state_q;
    done_d      = done;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    word_d      = word_q;
    row_d       = row_q;
    col_d       = col_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    finished_d  = finished_q;
    cycles_d    = cycles_q;
    instrs_d    = instrs_q;
`ifdef MATRIX_RESULT_READER_CPI_EN
    cpi_d       = cpi_q;
    div_start_d = 1'b0;
`endif
    trigger_s = done & ~done_q;
    row_end_s = (col_q == 8'(N2 - 1));
    nxt_col_s = row_end_s ? 8'd0 : col_q + 8'd1;
    nxt_row_s = row_end_s ? row_q + 8'd1 : row_q;
    case (state_q)
      IDLE: begin
        if (trigger_s) begin
          state_d    = READ;
          cycles_d   = clock_count;
          instrs_d   = instr_cnt;
          row_d      = 8'd0;
          col_d      = 8'd0;
          cnt_d      = 3'd0;
          mem_addr_d = addr_of(8'd0, 8'd0);
          busy_d     = 1'b1;
`ifdef MATRIX_RESULT_READER_CPI_EN
          cpi_d      = 16'd0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        // Addresses go out on counts 0..2 after the base; bytes land one cycle later.
        if (cnt_q < 3'd3) begin
          mem_addr_d = mem_addr_q + ADDR_W'(1);
        end else begin
          mem_addr_d = mem_addr_q;
        end
        if (cnt_q != 3'd0) begin
          word_d = {word_q[23:0], mem_rdata};
        end else begin
          word_d = word_q;
        end
        if (cnt_q == 3'd4) begin
          state_d     = OUT;
          cnt_d       = 3'd0;
          out_valid_d = 1'b1;
          out_last_d  = (row_q == 8'(M - 1)) && row_end_s;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (out_last_q) begin
`ifdef MATRIX_RESULT_READER_CPI_EN
            state_d     = CPI;
            div_start_d = 1'b1;
`else
            state_d    = FINISHED;
            busy_d     = 1'b0;
            finished_d = 1'b1;
`endif
          end else begin
            state_d    = READ;
            row_d      = nxt_row_s;
            col_d      = nxt_col_s;
            cnt_d      = 3'd0;
            mem_addr_d = addr_of(nxt_row_s, nxt_col_s);
          end
        end else begin
          state_d = OUT;
        end
      end
`ifdef MATRIX_RESULT_READER_CPI_EN
      CPI: begin
        if (div_done_s) begin
          state_d    = FINISHED;
          cpi_d      = div_quo_s;
          busy_d     = 1'b0;
          finished_d = 1'b1;
        end else begin
          state_d = CPI;
        end
      end
`endif
      FINISHED: begin
        if (!done) begin
          state_d    = IDLE;
          finished_d = 1'b0;
        end else begin
          state_d = FINISHED;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        finished_d  = 1'b0;
      end
    endcase
  end

  // Controller and output registers.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      done_q      <= 1'b0;
      cnt_q       <= 3'd0;
      mem_addr_q  <= '0;
      word_q      <= 32'd0;
      row_q       <= 8'd0;
      col_q       <= 8'd0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      finished_q  <= 1'b0;
      cycles_q    <= 16'd0;
      instrs_q    <= 16'd0;
`ifdef MATRIX_RESULT_READER_CPI_EN
      cpi_q       <= 16'd0;
      div_start_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      word_q      <= word_d;
      row_q       <= row_d;
      col_q       <= col_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      finished_q  <= finished_d;
      cycles_q    <= cycles_d;
      instrs_q    <= instrs_d;
`ifdef MATRIX_RESULT_READER_CPI_EN
      cpi_q       <= cpi_d;
      div_start_q <= div_start_d;
`endif
    end
  end

`ifdef MATRIX_RESULT_READER_CPI_EN
  cpi_divider u_cpi_divider (
    .clk      (CLOCK_50),
    .rst_n    (RESET_N),
    .start    (div_start_q),
    .dividend ({cycles_q, {CPI_FRAC_BITS{1'b0}}}),
    .divisor  (instrs_q),
    .done     (div_done_s),
    .quotient (div_quo_s)
  );
  assign cpi_q8 = cpi_q;
`else
  assign cpi_q8 = 16'd0;
`endif

  assign mem_addr    = mem_addr_q;
  assign out_valid   = out_valid_q;
  assign out_data    = word_q;
  assign out_row     = row_q;
  assign out_col     = col_q;
  assign out_last    = out_last_q;
  assign busy        = busy_q;
  assign finished    = finished_q;
  assign cycles_snap = cycles_q;
  assign instrs_snap = instrs_q;

endmodule

// File: tb/tb_matrix_result_reader.sv
// Directed, table-driven bench for matrix_result_reader with a synchronous byte memory model.
module tb_matrix_result_reader;

  localparam int M = 2, N = 4, N2 = 2, ADDR_W = 8;

  logic              CLOCK_50 = 1'b0;
  logic              RESET_N  = 1'b0;
  logic              done     = 1'b0;
  logic [15:0]       clock_count = 16'd0;
  logic [15:0]       instr_cnt   = 16'd0;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata = 8'd0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [31:0]       out_data;
  logic [7:0]        out_row, out_col;
  logic              out_last, busy, finished;
  logic [15:0]       cycles_snap, instrs_snap, cpi_q8;

  matrix_result_reader #(.M(M), .N(N), .N2(N2), .ADDR_W(ADDR_W)) dut (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .done(done),
    .clock_count(clock_count), .instr_cnt(instr_cnt),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .out_last(out_last),
    .busy(busy), .finished(finished),
    .cycles_snap(cycles_snap), .instrs_snap(instrs_snap), .cpi_q8(cpi_q8)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  logic [7:0] mem [0:255];
  always @(posedge CLOCK_50) mem_rdata <= mem[mem_addr];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [127:0] bytes;   // bytes 64..79, byte 64 in the top 8 bits
    logic [127:0] words;   // expected words, word 0 in the top 32 bits
    logic [15:0]  cc;
    logic [15:0]  ic;
    logic [15:0]  cpi;
  } vec_t;

  vec_t vecs [4];

  task automatic run_vector(input int v, input int stall_word, input bit hold_done);
    int lat;
    int cnt;
    logic [31:0] exp_w;
    logic [15:0] exp_cpi;
    for (int i = 0; i < 16; i++) mem[64 + i] = vecs[v].bytes[127 - 8 * i -: 8];
    clock_count = vecs[v].cc;
    instr_cnt   = vecs[v].ic;
    @(negedge CLOCK_50);
    done = 1'b1;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    clock_count = 16'hDEAD;
    instr_cnt   = 16'hBEEF;
    if (!hold_done) done = 1'b0;
    check($sformatf("v%0d busy_after_trigger", v), {31'd0, busy}, 32'd1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge CLOCK_50);
      lat++;
    end
    check($sformatf("v%0d first_latency", v), lat, 32'd5);
    for (int w = 0; w < M * N2; w++) begin
      cnt = 0;
      while (!out_valid && cnt < 20) begin
        @(negedge CLOCK_50);
        cnt++;
      end
      exp_w = vecs[v].words[127 - 32 * w -: 32];
      check($sformatf("v%0d w%0d valid", v, w), {31'd0, out_valid}, 32'd1);
      check($sformatf("v%0d w%0d data", v, w), out_data, exp_w);
      check($sformatf("v%0d w%0d row", v, w), {24'd0, out_row}, w / N2);
      check($sformatf("v%0d w%0d col", v, w), {24'd0, out_col}, w % N2);
      check($sformatf("v%0d w%0d last", v, w), {31'd0, out_last}, (w == M * N2 - 1) ? 32'd1 : 32'd0);
      if (w == stall_word) begin
        out_ready = 1'b0;
        for (int k = 0; k < 7; k++) begin
          @(negedge CLOCK_50);
          check($sformatf("v%0d stall%0d valid", v, k), {31'd0, out_valid}, 32'd1);
          check($sformatf("v%0d stall%0d data", v, k), out_data, exp_w);
        end
        out_ready = 1'b1;
      end
      @(negedge CLOCK_50);
      check($sformatf("v%0d w%0d valid_drop", v, w), {31'd0, out_valid}, 32'd0);
    end
    cnt = 0;
    while (!finished && cnt < 80) begin
      @(negedge CLOCK_50);
      cnt++;
    end
`ifdef MATRIX_RESULT_READER_CPI_EN
    exp_cpi = vecs[v].cpi;
`else
    exp_cpi = 16'd0;
`endif
    check($sformatf("v%0d finished", v), {31'd0, finished}, 32'd1);
    check($sformatf("v%0d busy_done", v), {31'd0, busy}, 32'd0);
    check($sformatf("v%0d cycles_snap", v), {16'd0, cycles_snap}, {16'd0, vecs[v].cc});
    check($sformatf("v%0d instrs_snap", v), {16'd0, instrs_snap}, {16'd0, vecs[v].ic});
    check($sformatf("v%0d cpi_q8", v), {16'd0, cpi_q8}, {16'd0, exp_cpi});
  endtask

  initial begin
    int cnt;
    int bad;
    vecs[0] = '{128'h00000032_0000003C_00000072_0000008C,
                {32'sd50, 32'sd60, 32'sd114, 32'sd140}, 16'd300, 16'd100, 16'h0300};
    vecs[1] = '{128'hFFFFFFF6_FFFFFF9C_7FFFFFFF_80000000,
                {-32'sd10, -32'sd100, 32'sd2147483647, 32'h80000000}, 16'd1000, 16'd3, 16'hFFFF};
    vecs[2] = '{128'h12345678_00000001_0000FF00_FF000000,
                {32'd305419896, 32'd1, 32'd65280, 32'd4278190080}, 16'd500, 16'd0, 16'hFFFF};
    vecs[3] = '{128'h00000000_00000007_FFFFFFFF_00010000,
                {32'd0, 32'd7, -32'sd1, 32'd65536}, 16'd255, 16'd7, 16'h246D};
    for (int i = 0; i < 256; i++) mem[i] = 8'd0;
    for (int i = 0; i < 16; i++) mem[4 * i + 3] = 8'((i % 8) + 1);

    repeat (3) @(negedge CLOCK_50);
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst finished", {31'd0, finished}, 32'd0);
    check("rst mem_addr", {24'd0, mem_addr}, 32'd0);
    check("rst out_data", out_data, 32'd0);
    check("rst cycles_snap", {16'd0, cycles_snap}, 32'd0);
    check("rst cpi_q8", {16'd0, cpi_q8}, 32'd0);
    RESET_N = 1'b1;

    run_vector(0, -1, 1'b0);
    run_vector(1, -1, 1'b0);
    run_vector(0, 1, 1'b0);
    run_vector(3, -1, 1'b1);

    // done held high after completion must not retrigger
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLOCK_50);
      if (out_valid || !finished) bad++;
    end
    check("hold_done no_retrigger", bad, 32'd0);
    done = 1'b0;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    check("rearm finished_low", {31'd0, finished}, 32'd0);
    run_vector(2, -1, 1'b0);

    // Reset during READ of word 2
    @(negedge CLOCK_50);
    done = 1'b1;
    @(negedge CLOCK_50);
    done = 1'b0;
    cnt = 0;
    while (!(out_row == 8'd1 && !out_valid && busy) && cnt < 60) begin
      @(negedge CLOCK_50);
      cnt++;
    end
    check("reset reached_word2", {24'd0, out_row}, 32'd1);
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    RESET_N = 1'b0;
    #1;
    check("midrst out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst busy", {31'd0, busy}, 32'd0);
    check("midrst mem_addr", {24'd0, mem_addr}, 32'd0);
    check("midrst out_data", out_data, 32'd0);
    check("midrst out_row", {24'd0, out_row}, 32'd0);
    check("midrst cycles_snap", {16'd0, cycles_snap}, 32'd0);
    @(negedge CLOCK_50);
    RESET_N = 1'b1;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLOCK_50);
      if (out_valid || busy) bad++;
    end
    check("postrst idle", bad, 32'd0);
    run_vector(0, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
